// File: rtl/storage_cache_ctrl.sv
// storage_cache_ctrl: scratchpad plus read-only direct-mapped flash cache with SPI programming passthrough
module storage_cache_ctrl #(
    parameter int MEM_W       = 32,
    parameter int SPM_WORDS   = 2048,
    parameter int LINE_WORDS  = 4,
    parameter int CACHE_LINES = 16,
    parameter int FLASH_AW    = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [MEM_W/8-1:0]    be,
    input  logic [MEM_W-1:0]      wdata,
    output logic                  gnt,
    output logic                  rvalid,
    output logic [MEM_W-1:0]      rdata,
    output logic                  err,
    output logic                  fl_req,
    output logic [FLASH_AW-1:0]   fl_addr,
    input  logic                  fl_ack,
    input  logic [MEM_W-1:0]      fl_rdata,
    input  logic                  prog_en,
    output logic                  prog_active,
    input  logic                  prg_cs_n,
    input  logic                  prg_sck,
    input  logic                  prg_mosi,
    output logic                  prg_miso,
    input  logic                  fsh_cs_n,
    input  logic                  fsh_sck,
    input  logic                  fsh_mosi,
    input  logic                  fsh_miso,
    output logic                  ext_cs_n,
    output logic                  ext_sck,
    output logic                  ext_mosi,
    input  logic                  ext_miso
);
    localparam int NB = MEM_W / 8;
    localparam int BO = $clog2(NB);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(CACHE_LINES);
    localparam int SW = $clog2(SPM_WORDS);
    localparam int LA = FLASH_AW - BO;
    localparam int TW = LA - OW - IW;
    localparam logic [31:0] SPM_BYTES = 32'(SPM_WORDS * NB);

    typedef enum logic [1:0] {IDLE, RESP, FILL, PROG} state_t;

    state_t                 state;
    logic [MEM_W-1:0]       spm [SPM_WORDS];
    logic [MEM_W-1:0]       line_data [CACHE_LINES*LINE_WORDS];
    logic [TW-1:0]          tags [CACHE_LINES];
    logic [CACHE_LINES-1:0] valid;
    logic [LA-1:0]          la;
    logic [OW-1:0]          cnt;
    logic                   miss;
    logic                   is_spm;
    logic                   hit;
    logic                   last;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          l_idx;
    logic [OW-1:0]          off;
    logic [OW-1:0]          l_off;
    logic [TW-1:0]          tag;
    logic [TW-1:0]          l_tag;
    logic                   unused_ok;

    assign is_spm = addr < SPM_BYTES;
    assign off    = addr[BO +: OW];
    assign idx    = addr[BO+OW +: IW];
    assign tag    = addr[BO+OW+IW +: TW];
    assign l_off  = la[0 +: OW];
    assign l_idx  = la[OW +: IW];
    assign l_tag  = la[OW+IW +: TW];
    assign hit    = valid[idx] && tags[idx] == tag;
    assign last   = cnt == OW'(LINE_WORDS - 1);
    assign gnt    = rst && state == IDLE && req && !prog_en;

    assign ext_cs_n  = prog_active ? prg_cs_n : fsh_cs_n;
    assign ext_sck   = prog_active ? prg_sck  : fsh_sck;
    assign ext_mosi  = prog_active ? prg_mosi : fsh_mosi;
    assign prg_miso  = prog_active & ext_miso;
    assign unused_ok = fsh_miso;

    always_ff @(posedge clk)
        if (gnt && we && is_spm)
            for (int i = 0; i < NB; i++)
                if (be[i]) spm[addr[BO +: SW]][i*8 +: 8] <= wdata[i*8 +: 8];

    always_ff @(posedge clk) begin
        if (state == FILL && fl_ack) line_data[{l_idx, cnt}] <= fl_rdata;
        if (state == FILL && fl_ack && last) tags[l_idx] <= l_tag;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            valid       <= '0;
            rvalid      <= 1'b0;
            err         <= 1'b0;
            fl_req      <= 1'b0;
            prog_active <= 1'b0;
            rdata       <= '0;
            miss        <= 1'b0;
            cnt         <= '0;
            la          <= '0;
            fl_addr     <= '0;
        end else begin
            case (state)
                IDLE:
                    if (prog_en) begin
                        state       <= PROG;
                        prog_active <= 1'b1;
                        valid       <= '0;
                    end else if (gnt) begin
                        state  <= RESP;
                        la     <= addr[FLASH_AW-1:BO];
                        miss   <= !is_spm && !we && !hit;
                        rvalid <= is_spm || we || hit;
                        err    <= !is_spm && we;
                        rdata  <= we ? '0 : is_spm ? spm[addr[BO +: SW]] : line_data[{idx, off}];
                    end
                RESP: begin
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                    state  <= miss ? FILL : IDLE;
                    if (miss) begin
                        fl_req  <= 1'b1;
                        cnt     <= '0;
                        fl_addr <= {la[LA-1:OW], {OW{1'b0}}, {BO{1'b0}}};
                    end
                end
                FILL:
                    if (fl_ack) begin
                        if (cnt == l_off) rdata <= fl_rdata;
                        if (last) begin
                            fl_req       <= 1'b0;
                            valid[l_idx] <= 1'b1;
                            miss         <= 1'b0;
                            rvalid       <= 1'b1;
                            state        <= RESP;
                        end else begin
                            cnt     <= cnt + 1'b1;
                            fl_addr <= {la[LA-1:OW], cnt + 1'b1, {BO{1'b0}}};
                        end
                    end
                PROG:
                    if (!prog_en) begin
                        state       <= IDLE;
                        prog_active <= 1'b0;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_storage_cache_ctrl.sv
// tb_storage_cache_ctrl: scoreboard bench with a flash responder returning each word's address as data
module tb_storage_cache_ctrl;
    logic        clk = 1'b0, rst = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt, rvalid, err, fl_req, prog_active;
    logic [31:0] rdata;
    logic [21:0] fl_addr;
    logic        fl_ack = 1'b0;
    logic [31:0] fl_rdata = '0;
    logic        prog_en = 1'b0;
    logic        prg_cs_n = 1'b1, prg_sck = 1'b0, prg_mosi = 1'b0, prg_miso;
    logic        fsh_cs_n = 1'b1, fsh_sck = 1'b0, fsh_mosi = 1'b0, fsh_miso = 1'b0;
    logic        ext_cs_n, ext_sck, ext_mosi, ext_miso = 1'b0;

    typedef struct {logic [31:0] d; logic e; int lat; int g;} exp_t;
    exp_t        sb[$];
    logic [21:0] fl_log[$];
    int          n_vec = 0, n_bad = 0, cyc = 0, fl_cnt = 0;

    storage_cache_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
        .fl_req(fl_req), .fl_addr(fl_addr), .fl_ack(fl_ack), .fl_rdata(fl_rdata),
        .prog_en(prog_en), .prog_active(prog_active),
        .prg_cs_n(prg_cs_n), .prg_sck(prg_sck), .prg_mosi(prg_mosi), .prg_miso(prg_miso),
        .fsh_cs_n(fsh_cs_n), .fsh_sck(fsh_sck), .fsh_mosi(fsh_mosi), .fsh_miso(fsh_miso),
        .ext_cs_n(ext_cs_n), .ext_sck(ext_sck), .ext_mosi(ext_mosi), .ext_miso(ext_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid pops one expected response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_rvalid: got rdata %h, expected no response", rdata);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("err", 32'(err), 32'(e.e));
                    chk("latency", 32'(cyc - e.g), 32'(e.lat));
                end
            end
        end
    end

    // Flash responder: one-cycle ack, then one idle cycle
    initial forever begin
        @(negedge clk);
        if (fl_ack) fl_ack = 1'b0;
        else if (fl_req === 1'b1) begin
            fl_log.push_back(fl_addr);
            fl_rdata = 32'(fl_addr);
            fl_ack = 1'b1;
            fl_cnt++;
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] ed, input logic ee, input int lat);
        exp_t e;
        int   k = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1;
        while (!gnt && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!gnt) begin
            n_vec++;
            n_bad++;
            $display("FAIL grant: got gnt=0 expected gnt=1 for addr %h", a);
        end else begin
            e.d = ed; e.e = ee; e.lat = lat; e.g = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL response_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed, input int lat);
        issue(1'b0, a, 4'h0, 32'h0, ed, 1'b0, lat);
        drain();
    endtask

    task automatic chk_fill(input string name, input logic [21:0] base);
        chk({name, "_count"}, 32'(fl_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < fl_log.size(); i++)
            chk({name, "_addr"}, 32'(fl_log[i]), 32'(base + 22'(4 * i)));
        fl_log.delete();
    endtask

    initial begin
        int k;
        int tgt;
        // reset state, with a request held to confirm gnt is suppressed
        req = 1'b1; ext_miso = 1'b1; fsh_sck = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_fl_req", 32'(fl_req), 32'd0);
        chk("rst_prog_active", 32'(prog_active), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ext_sck", 32'(ext_sck), 32'd1);
        chk("rst_prg_miso", 32'(prg_miso), 32'd0);
        req = 1'b0; rst = 1'b1; ext_miso = 1'b0; fsh_sck = 1'b0;
        // scratchpad byte-enable write
        issue(1'b1, 32'h10, 4'hf, 32'h0, 32'h0, 1'b0, 1); drain();
        issue(1'b1, 32'h10, 4'b0101, 32'hDEADBEEF, 32'h0, 1'b0, 1); drain();
        rd(32'h10, 32'h00AD00EF, 1);
        chk("spm_no_flash", 32'(fl_log.size()), 32'd0);
        // miss then hit
        rd(32'h4008, 32'h4008, 9);
        chk_fill("miss_fill", 22'h4000);
        rd(32'h400C, 32'h400C, 1);
        chk("hit_no_flash", 32'(fl_log.size()), 32'd0);
        // conflicting line at the same index
        rd(32'h4000, 32'h4000, 1);
        rd(32'h4100, 32'h4100, 9);
        chk_fill("conflict_fill", 22'h4100);
        rd(32'h4000, 32'h4000, 9);
        chk_fill("refill", 22'h4000);
        // write to flash region is dropped with err
        issue(1'b1, 32'h4000, 4'hf, 32'h12345678, 32'h0, 1'b1, 1); drain();
        rd(32'h4004, 32'h4004, 1);
        chk("flash_wr_no_flash", 32'(fl_log.size()), 32'd0);
        // programming request during a fill
        issue(1'b0, 32'h4018, 4'h0, 32'h0, 32'h4018, 1'b0, 9);
        repeat (3) @(negedge clk);
        prog_en = 1'b1;
        drain();
        k = 0;
        while (!prog_active && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("prog_active_on", 32'(prog_active), 32'd1);
        chk_fill("prog_fill", 22'h4010);
        prg_sck = 1'b1; fsh_sck = 1'b0; ext_miso = 1'b1; req = 1'b1;
        #1;
        chk("prog_ext_sck_hi", 32'(ext_sck), 32'd1);
        chk("prog_prg_miso", 32'(prg_miso), 32'd1);
        chk("prog_gnt", 32'(gnt), 32'd0);
        prg_sck = 1'b0; fsh_sck = 1'b1;
        #1;
        chk("prog_ext_sck_lo", 32'(ext_sck), 32'd0);
        @(negedge clk);
        req = 1'b0; prog_en = 1'b0;
        @(negedge clk);
        #1;
        chk("prog_active_off", 32'(prog_active), 32'd0);
        chk("ext_sck_back", 32'(ext_sck), 32'd1);
        fsh_sck = 1'b0; ext_miso = 1'b0;
        rd(32'h4008, 32'h4008, 9);
        chk_fill("post_prog_fill", 22'h4000);
        // reset after the second flash ack of a fill
        tgt = fl_cnt + 2;
        issue(1'b0, 32'h4028, 4'h0, 32'h0, 32'h4028, 1'b0, 9);
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (!(fl_ack && fl_cnt == tgt) && k < 50);
        chk("second_ack_seen", 32'(fl_cnt), 32'(tgt));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_fl_req", 32'(fl_req), 32'd0);
        chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b1;
        sb.delete();
        fl_log.delete();
        rd(32'h4028, 32'h4028, 9);
        chk_fill("post_rst_fill", 22'h4020);
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
